// File: rtl/conv_allocator_gen.sv
// Convolution compute unit producing one output pixel per job: window filtering, operand
// buffering, a 3-stage signed MAC pipe, bias, ReLU/leaky activation and saturation.
module conv_allocator_gen #(
  parameter int DATA_W     = 18,
  parameter int COORD_W    = 8,
  parameter int CNT_W      = 13,
  parameter int BUF_DEPTH  = 512,
  parameter int ACC_W      = 48,
  parameter int LEAK_MODE  = 0,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [COORD_W-1:0]        cfg_center_x,
  input  logic [COORD_W-1:0]        cfg_center_y,
  input  logic [1:0]                cfg_halfsize,
  input  logic [CNT_W-1:0]          cfg_length,
  input  logic signed [DATA_W-1:0]  cfg_bias,
  input  logic                      img_valid,
  output logic                      img_ready,
  input  logic [COORD_W-1:0]        img_x,
  input  logic [COORD_W-1:0]        img_y,
  input  logic signed [DATA_W-1:0]  img_data,
  input  logic                      flt_valid,
  output logic                      flt_ready,
  input  logic signed [DATA_W-1:0]  flt_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [DATA_W-1:0]  res_data,
  output logic                      busy,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, RUN, BIAS, ACT, OUT} state_t;

  state_t state, next_state;

  logic [COORD_W-1:0]       center_x, center_y;
  logic [1:0]               half;
  logic [CNT_W-1:0]         len;
  logic signed [DATA_W-1:0] bias;

  logic signed [DATA_W-1:0] img_mem [BUF_DEPTH];
  logic signed [DATA_W-1:0] flt_mem [BUF_DEPTH];
  logic [PTR_W-1:0]         img_wr, img_rd, flt_wr, flt_rd;
  logic [OCC_W-1:0]         img_count, flt_count;
  logic [CNT_W-1:0]         img_stored, flt_stored, pop_cnt, mac_cnt;

  logic                     rd_valid, prod_valid;
  logic signed [DATA_W-1:0] img_q, flt_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] res_data_r;
  logic                     overflow_r;

  logic                     img_full, flt_full, img_empty, flt_empty;
  logic signed [COORD_W:0]  dx, dy, half_ext;
  logic                     hit, img_accept, img_push, img_drop, flt_push, pop;
  logic                     pipe_empty, cfg_start;
  logic signed [ACC_W-1:0]  act_val;
  logic signed [DATA_W-1:0] sat_val;

  assign img_full  = (img_count == OCC_W'(BUF_DEPTH));
  assign flt_full  = (flt_count == OCC_W'(BUF_DEPTH));
  assign img_empty = (img_count == '0);
  assign flt_empty = (flt_count == '0);

  // Differences are taken one bit wider and signed so the window never wraps at the image edges.
  assign dx       = $signed({1'b0, img_x}) - $signed({1'b0, center_x});
  assign dy       = $signed({1'b0, img_y}) - $signed({1'b0, center_y});
  assign half_ext = $signed({{(COORD_W-1){1'b0}}, half});
  assign hit      = (dx <= half_ext) && (dx >= -half_ext) &&
                    (dy <= half_ext) && (dy >= -half_ext);

  assign img_ready  = (state == RUN) && !img_full;
  assign flt_ready  = (state == RUN) && !flt_full && (flt_stored < len);
  assign img_accept = img_valid && img_ready;
  assign img_push   = img_accept && hit && (img_stored < len);
  assign img_drop   = img_accept && hit && !(img_stored < len);
  assign flt_push   = flt_valid && flt_ready;
  assign pop        = (state == RUN) && !img_empty && !flt_empty && (pop_cnt < len);
  assign pipe_empty = !rd_valid && !prod_valid;
  assign cfg_start  = (state == IDLE) && cfg_we;

  assign res_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign res_data  = res_data_r;
  assign overflow  = overflow_r;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cfg_we) next_state = RUN;
      RUN:  if ((mac_cnt == len) && pipe_empty) next_state = BIAS;
      BIAS: next_state = ACT;
      ACT:  next_state = OUT;
      OUT:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Activation first, then clamp the wide accumulator into the result width.
  always_comb begin
    act_val = acc;
    if (acc[ACC_W-1]) begin
      if (LEAK_MODE != 0) act_val = acc >>> LEAK_SHIFT;
      else                act_val = '0;
    end
    if (act_val > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (act_val < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = act_val[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (img_push) img_mem[img_wr] <= img_data;
    if (flt_push) flt_mem[flt_wr] <= flt_data;
    if (pop) begin
      img_q <= img_mem[img_rd];
      flt_q <= flt_mem[flt_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      center_x   <= '0;
      center_y   <= '0;
      half       <= '0;
      len        <= '0;
      bias       <= '0;
      img_wr     <= '0;
      img_rd     <= '0;
      flt_wr     <= '0;
      flt_rd     <= '0;
      img_count  <= '0;
      flt_count  <= '0;
      img_stored <= '0;
      flt_stored <= '0;
      pop_cnt    <= '0;
      mac_cnt    <= '0;
      rd_valid   <= 1'b0;
      prod_valid <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      res_data_r <= '0;
      overflow_r <= 1'b0;
    end else begin
      state <= next_state;
      if (cfg_start) begin
        center_x   <= cfg_center_x;
        center_y   <= cfg_center_y;
        half       <= cfg_halfsize;
        len        <= cfg_length;
        bias       <= cfg_bias;
        img_wr     <= '0;
        img_rd     <= '0;
        flt_wr     <= '0;
        flt_rd     <= '0;
        img_count  <= '0;
        flt_count  <= '0;
        img_stored <= '0;
        flt_stored <= '0;
        pop_cnt    <= '0;
        mac_cnt    <= '0;
        acc        <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (img_push) begin
          img_wr     <= img_wr + PTR_W'(1);
          img_stored <= img_stored + CNT_W'(1);
        end
        if (flt_push) begin
          flt_wr     <= flt_wr + PTR_W'(1);
          flt_stored <= flt_stored + CNT_W'(1);
        end
        if (pop) begin
          img_rd  <= img_rd + PTR_W'(1);
          flt_rd  <= flt_rd + PTR_W'(1);
          pop_cnt <= pop_cnt + CNT_W'(1);
        end
        img_count <= img_count + OCC_W'(img_push) - OCC_W'(pop);
        flt_count <= flt_count + OCC_W'(flt_push) - OCC_W'(pop);
        if (img_drop) overflow_r <= 1'b1;

        // MAC pipe: buffer read (stage 1) -> product register -> accumulate.
        rd_valid   <= pop;
        prod_valid <= rd_valid;
        if (rd_valid) prod <= img_q * flt_q;
        if (prod_valid) begin
          acc     <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          mac_cnt <= mac_cnt + CNT_W'(1);
        end

        if (state == BIAS) acc <= acc + {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
        if (state == ACT)  res_data_r <= sat_val;
        if ((state == OUT) && res_ready) acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_allocator_gen.sv
// Directed bench for conv_allocator_gen: a ReLU and a leaky instance share all inputs,
// and results are compared against hand-computed values.
module tb_conv_allocator_gen;

  localparam int DATA_W  = 18;
  localparam int COORD_W = 8;
  localparam int CNT_W   = 13;

  typedef struct packed {
    logic [COORD_W-1:0]       x;
    logic [COORD_W-1:0]       y;
    logic signed [DATA_W-1:0] d;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cfg_we;
  logic [COORD_W-1:0]        cfg_center_x, cfg_center_y;
  logic [1:0]                cfg_halfsize;
  logic [CNT_W-1:0]          cfg_length;
  logic signed [DATA_W-1:0]  cfg_bias;
  logic                      img_valid, flt_valid, res_ready;
  logic [COORD_W-1:0]        img_x, img_y;
  logic signed [DATA_W-1:0]  img_data, flt_data;
  logic                      img_ready, flt_ready, res_valid, busy, overflow;
  logic signed [DATA_W-1:0]  res_data;
  logic                      img_ready_l, flt_ready_l, res_valid_l, busy_l, overflow_l;
  logic signed [DATA_W-1:0]  res_data_l;

  int    checks = 0;
  int    errors = 0;
  int    flt_acc = 0;
  int    lat;
  beat_t img_q[$];
  logic signed [DATA_W-1:0] flt_q[$];

  always #5 clk = ~clk;

  conv_allocator_gen #(.LEAK_MODE(0)) u_relu (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_center_x(cfg_center_x), .cfg_center_y(cfg_center_y),
    .cfg_halfsize(cfg_halfsize), .cfg_length(cfg_length), .cfg_bias(cfg_bias),
    .img_valid(img_valid), .img_ready(img_ready), .img_x(img_x), .img_y(img_y),
    .img_data(img_data), .flt_valid(flt_valid), .flt_ready(flt_ready),
    .flt_data(flt_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .overflow(overflow)
  );

  conv_allocator_gen #(.LEAK_MODE(1), .LEAK_SHIFT(3)) u_leak (
    .clk(clk), .rst(rst), .cfg_we(cfg_we),
    .cfg_center_x(cfg_center_x), .cfg_center_y(cfg_center_y),
    .cfg_halfsize(cfg_halfsize), .cfg_length(cfg_length), .cfg_bias(cfg_bias),
    .img_valid(img_valid), .img_ready(img_ready_l), .img_x(img_x), .img_y(img_y),
    .img_data(img_data), .flt_valid(flt_valid), .flt_ready(flt_ready_l),
    .flt_data(flt_data), .res_valid(res_valid_l), .res_ready(res_ready),
    .res_data(res_data_l), .busy(busy_l), .overflow(overflow_l)
  );

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] h, input int cx, input int cy,
                               input int len, input int bias);
    @(negedge clk);
    cfg_halfsize = h;
    cfg_center_x = COORD_W'(cx);
    cfg_center_y = COORD_W'(cy);
    cfg_length   = CNT_W'(len);
    cfg_bias     = DATA_W'(bias);
    cfg_we       = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drive_img(input int budget);
    int n = 0;
    while (img_q.size() > 0 && n < budget) begin
      @(negedge clk);
      img_valid = 1'b1;
      img_x     = img_q[0].x;
      img_y     = img_q[0].y;
      img_data  = img_q[0].d;
      if (img_ready) void'(img_q.pop_front());
      n++;
    end
    @(negedge clk);
    img_valid = 1'b0;
    if (img_q.size() > 0) checkOutput("img_budget", img_q.size(), 0);
    img_q.delete();
  endtask

  task automatic drive_flt(input int budget);
    int n = 0;
    while (flt_q.size() > 0 && n < budget) begin
      @(negedge clk);
      flt_valid = 1'b1;
      flt_data  = flt_q[0];
      if (flt_ready) begin
        void'(flt_q.pop_front());
        flt_acc++;
      end
      n++;
    end
    @(negedge clk);
    flt_valid = 1'b0;
    if (flt_q.size() > 0) checkOutput("flt_budget", flt_q.size(), 0);
    flt_q.delete();
  endtask

  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("res_timeout", res_valid, 1);
    checkOutput("res_pair", res_valid_l, res_valid);
  endtask

  task automatic finish_job();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("res_drop", res_valid, 0);
    checkOutput("busy_idle", busy, 0);
    checkOutput("busy_idle_l", busy_l, 0);
  endtask

  task automatic load_window(input int cx, input int cy, input int data);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        img_q.push_back('{x: COORD_W'(cx + dx), y: COORD_W'(cy + dy), d: DATA_W'(data)});
  endtask

  task automatic load_flt(input int n, input int w);
    for (int i = 0; i < n; i++) flt_q.push_back(DATA_W'(w));
  endtask

  task automatic load_center(input int n, input int data);
    for (int i = 0; i < n; i++)
      img_q.push_back('{x: COORD_W'(10), y: COORD_W'(10), d: DATA_W'(data)});
  endtask

  task automatic run_simple(input string tag, input int len, input int bias,
                            input int exp_relu, input int exp_leak);
    applyStimulus(2'd1, 10, 10, len, bias);
    drive_img(200);
    drive_flt(200);
    wait_result(100, lat);
    checkOutput({tag, "_relu"}, res_data, exp_relu);
    checkOutput({tag, "_leak"}, res_data_l, exp_leak);
    finish_job();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_center_x = '0; cfg_center_y = '0;
    cfg_halfsize = '0; cfg_length = '0; cfg_bias = '0;
    img_valid = 1'b0; img_x = '0; img_y = '0; img_data = '0;
    flt_valid = 1'b0; flt_data = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_img_ready", img_ready, 0);
    checkOutput("rst_flt_ready", flt_ready, 0);
    checkOutput("rst_img_ready_l", img_ready_l, 0);
    checkOutput("rst_flt_ready_l", flt_ready_l, 0);
    checkOutput("rst_overflow_l", overflow_l, 0);

    // Basic 3x3 job: 9*(2*3)+4 = 58; last pair pops one edge after the last weight.
    load_window(10, 10, 2);
    load_flt(9, 3);
    applyStimulus(2'd1, 10, 10, 9, 4);
    checkOutput("busy_run", busy, 1);
    drive_img(100);
    drive_flt(100);
    wait_result(100, lat);
    checkOutput("latency", lat, 6);
    checkOutput("basic_relu", res_data, 58);
    checkOutput("basic_leak", res_data_l, 58);
    checkOutput("basic_ovf", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_data", res_data, 58);
    end
    finish_job();

    // Out-of-window beats interleaved, including one that would wrap if unsigned.
    load_window(10, 10, 2);
    img_q.insert(2, '{x: 8'd12, y: 8'd10, d: 18'sd50});
    img_q.insert(5, '{x: 8'd10, y: 8'd8, d: 18'sd50});
    img_q.insert(7, '{x: 8'd255, y: 8'd10, d: 18'sd50});
    load_flt(9, 3);
    run_simple("filtered", 9, 4, 58, 58);
    checkOutput("filtered_ovf", overflow, 0);

    // A tenth hit overflows but does not disturb the result.
    load_window(10, 10, 2);
    load_center(1, 7);
    load_flt(9, 3);
    applyStimulus(2'd1, 10, 10, 9, 4);
    drive_img(100);
    checkOutput("ovf_set", overflow, 1);
    drive_flt(100);
    wait_result(100, lat);
    checkOutput("ovf_result", res_data, 58);
    finish_job();
    checkOutput("ovf_sticky", overflow, 1);

    // Zero-length job: result is just the bias; the new cfg clears overflow.
    applyStimulus(2'd1, 10, 10, 0, 7);
    checkOutput("ovf_cleared", overflow, 0);
    wait_result(20, lat);
    checkOutput("len0_relu", res_data, 7);
    checkOutput("len0_leak", res_data_l, 7);
    finish_job();

    // Sum -84 + 4 = -80: ReLU 0, leaky -80>>>3 = -10.
    load_center(4, -21);
    load_flt(4, 1);
    run_simple("neg", 4, 4, 0, -10);

    load_center(4, 131071);
    load_flt(4, 131071);
    run_simple("satpos", 4, 0, 131071, 131071);

    load_center(4, -131072);
    load_flt(4, 131071);
    run_simple("satneg", 4, -1, 0, -131072);

    // Weights far ahead of images: buffer fills at 512, then drains as MACs pop.
    load_center(600, 1);
    load_flt(600, 1);
    flt_acc = 0;
    applyStimulus(2'd1, 10, 10, 600, 0);
    fork
      drive_flt(4000);
      begin
        repeat (600) @(negedge clk);
        checkOutput("flt_full_ready", flt_ready, 0);
        checkOutput("flt_full_cnt", flt_acc, 512);
        drive_img(4000);
      end
    join
    checkOutput("flt_all", flt_acc, 600);
    wait_result(100, lat);
    checkOutput("bp_relu", res_data, 600);
    checkOutput("bp_leak", res_data_l, 600);
    finish_job();

    // Reset mid-job aborts it; the following job is unaffected.
    load_center(3, 2);
    applyStimulus(2'd1, 10, 10, 9, 4);
    drive_img(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", res_valid, 0);
    checkOutput("abort_img_ready", img_ready, 0);
    load_window(10, 10, 2);
    load_flt(9, 3);
    run_simple("after_rst", 9, 4, 58, 58);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
